// File: rtl/alu_dec.sv
// -----------------------------------------------------------------------------
// alu_dec : registered instruction decode stage feeding the exe-stage ALU.
//
// Decodes a 32-bit instruction (tagged with a thread id) into the ALU control
// bundle plus register indices, write enable, compare flag and illegal flag.
// Two storage slots sit between fetch and exe: a main register M that drives
// every out_* port and a skid register S that absorbs the one extra
// instruction that can arrive while in_ready is still high after exe stalls.
// in_ready comes from a flop, so exe back-pressure never reaches fetch
// through combinational logic.
//
// Handshake: a beat moves on a rising edge when valid & ready are both high
// on that channel. A producer keeps valid and its payload steady until the
// beat moves. out_* are held stable while out_valid & ~out_ready. flush
// drops both slots and any beat offered in the same cycle.
//
// Optional build macro: DEC_ILL_TRAP_EN
//   defined   : per-thread sticky trap bits, exported on ill_trap. Once a
//               thread is trapped, all its later instructions are emitted as
//               NOP with out_ill = 1 until flush or reset.
//   undefined : an illegal opcode only affects that one instruction.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   flush           synchronous flush of both slots (and trap bits)
//   in_valid/ready  fetch-side handshake (in_ready registered)
//   in_instr        instruction word
//   in_tid          thread id
//   out_valid/ready exe-side handshake
//   out_alu_op      ALU op code
//   out_i_type      1 = ALU B operand is the immediate
//   out_imm         instr[15:0] (0 for NOP)
//   out_rd/rs1/rs2  register indices
//   out_we          register write enable
//   out_cmp         compare-only operation
//   out_tid         thread id of the bundle
//   out_ill         opcode was illegal (or thread trapped)
//   ill_trap        per-thread trap bits (DEC_ILL_TRAP_EN only)
// -----------------------------------------------------------------------------
module alu_dec #(
  parameter int TID_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TID_W-1:0] in_tid,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_alu_op,
  output logic             out_i_type,
  output logic [15:0]      out_imm,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic             out_we,
  output logic             out_cmp,
  output logic [TID_W-1:0] out_tid,
  output logic             out_ill
`ifdef DEC_ILL_TRAP_EN
  ,
  output logic [2**TID_W-1:0] ill_trap
`endif
);

  // ALU op encodings seen by exe
  localparam logic [2:0] ALU_NOT  = 3'b000;
  localparam logic [2:0] ALU_SHLT = 3'b001;
  localparam logic [2:0] ALU_SHRT = 3'b010;
  localparam logic [2:0] ALU_XOR  = 3'b011;
  localparam logic [2:0] ALU_SHAR = 3'b100;
  localparam logic [2:0] ALU_OR   = 3'b101;
  localparam logic [2:0] ALU_ADD  = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b111;

  // Opcode map (instr[31:27]); anything with bit 4 set is illegal
  localparam logic [4:0] OPC_NOP  = 5'b00000;
  localparam logic [4:0] OPC_ADD  = 5'b00001;
  localparam logic [4:0] OPC_ADDI = 5'b00010;
  localparam logic [4:0] OPC_AND  = 5'b00011;
  localparam logic [4:0] OPC_ANDI = 5'b00100;
  localparam logic [4:0] OPC_OR   = 5'b00101;
  localparam logic [4:0] OPC_ORI  = 5'b00110;
  localparam logic [4:0] OPC_XOR  = 5'b00111;
  localparam logic [4:0] OPC_XORI = 5'b01000;
  localparam logic [4:0] OPC_NOT  = 5'b01001;
  localparam logic [4:0] OPC_SLL  = 5'b01010;
  localparam logic [4:0] OPC_SRL  = 5'b01011;
  localparam logic [4:0] OPC_SRA  = 5'b01100;
  localparam logic [4:0] OPC_LIL  = 5'b01101;
  localparam logic [4:0] OPC_LIH  = 5'b01110;
  localparam logic [4:0] OPC_CMP  = 5'b01111;

  typedef struct packed {
    logic [2:0]       alu_op;
    logic             i_type;
    logic [15:0]      imm;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic             we;
    logic             cmp;
    logic [TID_W-1:0] tid;
    logic             ill;
  } bundle_t;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic    m_valid;
  bundle_t m_q;
  logic    s_valid;
  bundle_t s_q;
  logic    in_ready_q;

  logic [4:0] opc;
  logic       opc_illegal;
  logic       trapped;
  bundle_t    dec;
  logic       in_xfer;
  logic       m_free;

  assign opc         = in_instr[31:27];
  assign opc_illegal = opc[4];
  assign in_xfer     = in_valid & in_ready_q;
  // M can take a new bundle when it is empty or its bundle leaves this edge.
  assign m_free      = ~m_valid | out_ready;

`ifdef DEC_ILL_TRAP_EN
  logic [2**TID_W-1:0] trap_q;

  assign trapped  = trap_q[in_tid];
  assign ill_trap = trap_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_q <= '0;
    end else if (flush) begin
      trap_q <= '0;
    end else if (in_xfer && opc_illegal) begin
      trap_q[in_tid] <= 1'b1;
    end
  end
`else
  assign trapped = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Decode of the instruction currently offered by fetch
  // ---------------------------------------------------------------------------
  logic [4:0] eff_opc;

  always_comb begin
    // Illegal opcodes and trapped threads decode exactly as NOP.
    eff_opc = (opc_illegal | trapped) ? OPC_NOP : opc;

    dec        = '0;
    dec.alu_op = ALU_ADD;
    dec.i_type = 1'b0;
    dec.imm    = in_instr[15:0];
    dec.rd     = in_instr[26:22];
    dec.rs1    = in_instr[21:17];
    dec.rs2    = in_instr[16:12];
    dec.we     = 1'b1;
    dec.cmp    = 1'b0;
    dec.tid    = in_tid;
    dec.ill    = opc_illegal | trapped;

    case (eff_opc)
      OPC_ADD:  dec.alu_op = ALU_ADD;
      OPC_ADDI: begin dec.alu_op = ALU_ADD;  dec.i_type = 1'b1; end
      OPC_AND:  dec.alu_op = ALU_AND;
      OPC_ANDI: begin dec.alu_op = ALU_AND;  dec.i_type = 1'b1; end
      OPC_OR:   dec.alu_op = ALU_OR;
      OPC_ORI:  begin dec.alu_op = ALU_OR;   dec.i_type = 1'b1; end
      OPC_XOR:  dec.alu_op = ALU_XOR;
      OPC_XORI: begin dec.alu_op = ALU_XOR;  dec.i_type = 1'b1; end
      OPC_NOT:  dec.alu_op = ALU_NOT;
      // Shifts take their amount from imm[4:0] but keep i_type low.
      OPC_SLL:  dec.alu_op = ALU_SHLT;
      OPC_SRL:  dec.alu_op = ALU_SHRT;
      OPC_SRA:  dec.alu_op = ALU_SHAR;
      OPC_LIL:  begin dec.alu_op = ALU_SHLT; dec.i_type = 1'b1; end
      OPC_LIH: begin
        // rd = rd<<16 | imm : the ALU reads the old rd on port A.
        dec.alu_op = ALU_SHRT;
        dec.i_type = 1'b1;
        dec.rs1    = in_instr[26:22];
      end
      OPC_CMP: begin
        dec.alu_op = ALU_ADD;
        dec.we     = 1'b0;
        dec.cmp    = 1'b1;
      end
      default: begin
        // NOP (also covers illegal / trapped)
        dec.alu_op = ALU_ADD;
        dec.i_type = 1'b1;
        dec.we     = 1'b0;
        dec.rd     = 5'd0;
        dec.imm    = 16'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // M / S movement
  // S only fills while M is holding, and in_ready is low whenever S is valid,
  // so "S -> M" and "input -> anywhere" never happen on the same edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid    <= 1'b0;
      m_q        <= '0;
      s_valid    <= 1'b0;
      s_q        <= '0;
      in_ready_q <= 1'b1;
    end else if (flush) begin
      m_valid    <= 1'b0;
      s_valid    <= 1'b0;
      in_ready_q <= 1'b1;
    end else if (m_free) begin
      if (s_valid) begin
        m_q        <= s_q;
        m_valid    <= 1'b1;
        s_valid    <= 1'b0;
        in_ready_q <= 1'b1;
      end else if (in_xfer) begin
        m_q     <= dec;
        m_valid <= 1'b1;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (in_xfer) begin
      // M is stalled: park the new bundle and close the input next cycle.
      s_q        <= dec;
      s_valid    <= 1'b1;
      in_ready_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs come straight from M
  // ---------------------------------------------------------------------------
  assign in_ready   = in_ready_q;
  assign out_valid  = m_valid;
  assign out_alu_op = m_q.alu_op;
  assign out_i_type = m_q.i_type;
  assign out_imm    = m_q.imm;
  assign out_rd     = m_q.rd;
  assign out_rs1    = m_q.rs1;
  assign out_rs2    = m_q.rs2;
  assign out_we     = m_q.we;
  assign out_cmp    = m_q.cmp;
  assign out_tid    = m_q.tid;
  assign out_ill    = m_q.ill;

endmodule

// File: tb/tb_alu_dec.sv
// -----------------------------------------------------------------------------
// tb_alu_dec : self-checking bench for alu_dec.
// The expected queue holds the decoded bundles of every instruction that is
// inside the stage (M then S); its size gives out_valid and in_ready.
// -----------------------------------------------------------------------------
module tb_alu_dec;

  localparam int TID_W = 2;
  localparam int W     = 40;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_instr = '0;
  logic [TID_W-1:0] in_tid = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [2:0]       out_alu_op;
  logic             out_i_type;
  logic [15:0]      out_imm;
  logic [4:0]       out_rd;
  logic [4:0]       out_rs1;
  logic [4:0]       out_rs2;
  logic             out_we;
  logic             out_cmp;
  logic [TID_W-1:0] out_tid;
  logic             out_ill;
`ifdef DEC_ILL_TRAP_EN
  logic [2**TID_W-1:0] ill_trap;
`endif

  always #5 clk = ~clk;

  alu_dec #(.TID_W(TID_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_tid     (in_tid),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_alu_op (out_alu_op),
    .out_i_type (out_i_type),
    .out_imm    (out_imm),
    .out_rd     (out_rd),
    .out_rs1    (out_rs1),
    .out_rs2    (out_rs2),
    .out_we     (out_we),
    .out_cmp    (out_cmp),
    .out_tid    (out_tid),
    .out_ill    (out_ill)
`ifdef DEC_ILL_TRAP_EN
    ,
    .ill_trap   (ill_trap)
`endif
  );

  // ---------------------------------------------------------------------------
  // Reference model: opcode tables indexed by opcode 0..15
  // ---------------------------------------------------------------------------
  logic [2:0] alu_tab [16] = '{3'b110, 3'b110, 3'b110, 3'b111, 3'b111, 3'b101,
                               3'b101, 3'b011, 3'b011, 3'b000, 3'b001, 3'b010,
                               3'b100, 3'b001, 3'b010, 3'b110};
  logic       it_tab  [16] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                               1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic       we_tab  [16] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                               1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  logic [W-1:0]        exp_q[$];
  logic [2**TID_W-1:0] trap_m = '0;

  function automatic logic [W-1:0] model(input logic [31:0] ins,
                                         input logic [TID_W-1:0] tid,
                                         input logic trapped);
    logic [4:0]  opc;
    logic        ill;
    int          k;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [15:0] imm;
    logic        cmp;
    opc = ins[31:27];
    ill = opc[4] | trapped;
    k   = ill ? 0 : int'(opc);
    rd  = (k == 0)  ? 5'd0  : ins[26:22];
    rs1 = (k == 14) ? ins[26:22] : ins[21:17];
    imm = (k == 0)  ? 16'd0 : ins[15:0];
    cmp = (k == 15);
    return {alu_tab[k], it_tab[k], imm, rd, rs1, ins[16:12], we_tab[k], cmp, tid, ill};
  endfunction

  function automatic logic [W-1:0] pack_exp(input logic [2:0] alu, input logic it,
                                            input logic [15:0] imm, input logic [4:0] rd,
                                            input logic [4:0] rs1, input logic [4:0] rs2,
                                            input logic we, input logic cmp,
                                            input logic [TID_W-1:0] tid, input logic ill);
    return {alu, it, imm, rd, rs1, rs2, we, cmp, tid, ill};
  endfunction

  logic [W-1:0] out_pack;
  assign out_pack = {out_alu_op, out_i_type, out_imm, out_rd, out_rs1, out_rs2,
                     out_we, out_cmp, out_tid, out_ill};

  // ---------------------------------------------------------------------------
  // Scoreboard bookkeeping
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Compare process: every falling edge, then advance the model to what the
  // next rising edge will do.
  // ---------------------------------------------------------------------------
  logic         stalled = 1'b0;
  logic [W-1:0] held = '0;

  always @(negedge clk) begin
    logic trapped;
    if (!rst_n) begin
      exp_q.delete();
      trap_m  = '0;
      stalled = 1'b0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
    end else begin
      chk("out_valid", out_valid, exp_q.size() != 0);
      chk("in_ready", in_ready, exp_q.size() < 2);
      if (out_valid && exp_q.size() != 0) chk("bundle", out_pack, exp_q[0]);
      if (stalled && out_valid) chk("stable", out_pack, held);
`ifdef DEC_ILL_TRAP_EN
      chk("ill_trap", ill_trap, trap_m);
      trapped = trap_m[in_tid];
`else
      trapped = 1'b0;
`endif
      stalled = out_valid & ~out_ready & ~flush;
      held    = out_pack;
      if (flush) begin
        exp_q.delete();
        trap_m = '0;
      end else begin
        if (out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
        if (in_valid && in_ready) begin
          exp_q.push_back(model(in_instr, in_tid, trapped));
`ifdef DEC_ILL_TRAP_EN
          if (in_instr[31]) trap_m[in_tid] = 1'b1;
`endif
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (all called at posedge + 1)
  // ---------------------------------------------------------------------------
  task automatic send(input logic [31:0] ins, input logic [TID_W-1:0] tid);
    int   n;
    logic acc;
    n   = 0;
    acc = 1'b0;
    in_valid = 1'b1;
    in_instr = ins;
    in_tid   = tid;
    while (!acc && n < 20) begin
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    chk("send_accepted", acc, 1);
  endtask

  task automatic expect_out(input string name, input logic [2:0] alu, input logic it,
                            input logic [15:0] imm, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic we, input logic cmp,
                            input logic ill);
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_alu_op"}, out_alu_op, alu);
    chk({name, "_i_type"}, out_i_type, it);
    chk({name, "_imm"}, out_imm, imm);
    chk({name, "_rd"}, out_rd, rd);
    chk({name, "_rs1"}, out_rs1, rs1);
    chk({name, "_we"}, out_we, we);
    chk({name, "_cmp"}, out_cmp, cmp);
    chk({name, "_ill"}, out_ill, ill);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom();
    if ($urandom_range(0, 9) == 0) r[31:27] = 5'($urandom_range(16, 31));
    else                           r[31:27] = 5'($urandom_range(0, 15));
    return r;
  endfunction

  // Offer n_instr random instructions; valid holds until the beat moves.
  task automatic stream(input int n_instr, input int ready_pct, input int flush_pct,
                        input int budget, input bit must_drain);
    int   sent;
    int   cyc;
    logic consumed;
    sent = 0;
    cyc  = 0;
    while ((sent < n_instr || (must_drain && exp_q.size() != 0)) && cyc < budget) begin
      if (!in_valid && sent < n_instr && $urandom_range(0, 99) < 75) begin
        in_valid = 1'b1;
        in_instr = rand_instr();
        in_tid   = TID_W'($urandom_range(0, 2**TID_W - 1));
      end
      out_ready = ($urandom_range(0, 99) < ready_pct);
      flush     = ($urandom_range(0, 99) < flush_pct);
      consumed  = in_valid & (in_ready | flush);
      @(posedge clk); #1;
      cyc++;
      if (consumed) begin
        sent++;
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    flush    = 1'b0;
    if (must_drain) chk("stream_drained", exp_q.size(), 0);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_pack", out_pack, 0);
    chk("reset_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Pin the model against hand-decoded bundles
    chk("model_addi", model(32'h1088_0123, 2'd0, 1'b0),
        pack_exp(3'b110, 1'b1, 16'h0123, 5'd2, 5'd4, 5'd0, 1'b1, 1'b0, 2'd0, 1'b0));
    chk("model_cmp", model(32'h7844_3000, 2'd3, 1'b0),
        pack_exp(3'b110, 1'b0, 16'h3000, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 2'd3, 1'b0));

    // ADDI: opc 00010, rd 2, rs1 4, imm 0x0123
    out_ready = 1'b1;
    send(32'h1088_0123, 2'd0);
    expect_out("addi", 3'b110, 1'b1, 16'h0123, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0);

    // LIH rd 7, rs1 field 3, imm 0xBEEF: rs1 follows rd
    send(32'h71C6_BEEF, 2'd2);
    expect_out("lih", 3'b010, 1'b1, 16'hBEEF, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0);

    // CMP: no write, compare flag
    send(32'h7844_3000, 2'd3);
    expect_out("cmp", 3'b110, 1'b0, 16'h3000, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0);

    // Illegal opcode 10101 on tid 1 -> NOP bundle with ill
    send(32'hA940_0000, 2'd1);
    expect_out("illegal", 3'b110, 1'b1, 16'h0000, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
`ifdef DEC_ILL_TRAP_EN
    @(posedge clk); #1;
    chk("trap_bit1", ill_trap[1], 1);
    send(32'h08C8_5000, 2'd1);
    expect_out("add_trapped", 3'b110, 1'b1, 16'h0000, 5'd0, 5'd4, 1'b0, 1'b0, 1'b1);
`else
    send(32'h08C8_5000, 2'd1);
    expect_out("add_tid1", 3'b110, 1'b0, 16'h5000, 5'd3, 5'd4, 1'b1, 1'b0, 1'b0);
`endif
    send(32'h08C8_5000, 2'd0);
    expect_out("add_tid0", 3'b110, 1'b0, 16'h5000, 5'd3, 5'd4, 1'b1, 1'b0, 1'b0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;

    // Stall: fill M and S with exe stopped, then release
    stream(4, 0, 0, 6, 1'b0);
    chk("stall_in_ready", in_ready, 0);
    chk("stall_out_valid", out_valid, 1);
    stream(2, 100, 0, 60, 1'b1);

    // Both slots full, flush together with an offered input
    out_ready = 1'b0;
    stream(2, 0, 0, 8, 1'b0);
    in_valid = 1'b1;
    in_instr = 32'h08C8_5000;
    flush    = 1'b1;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Flush while in_ready is high: the offered instruction must vanish
    out_ready = 1'b0;
    stream(1, 0, 0, 6, 1'b0);
    in_valid = 1'b1;
    in_instr = 32'h1088_0123;
    flush    = 1'b1;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush2_out_valid", out_valid, 0);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Random traffic with back-pressure and occasional flush
    stream(150, 60, 3, 3000, 1'b1);
    stream(100, 25, 0, 3000, 1'b1);

    // Asynchronous reset mid-transfer
    out_ready = 1'b0;
    stream(2, 0, 0, 8, 1'b0);
    in_valid = 1'b1;
    in_instr = 32'h1088_0123;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_pack", out_pack, 0);
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_in_ready", in_ready, 1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    stream(40, 70, 0, 1000, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit
  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
